// File: rtl/op4_pack.sv
// op4_pack: groups a serial valid/ready word stream into 4-operand sets for the CSA stage.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_last upstream;
// a/b/d/e packed operands, out_count (1..4), out_valid/out_ready downstream;
// ref_sum (WIDTH+2) running group sum, present only when OP4_PACK_REFSUM_EN is defined.
module op4_pack #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [2:0]       out_count,
  output logic             out_valid,
  input  logic             out_ready
`ifdef OP4_PACK_REFSUM_EN
  ,
  output logic [WIDTH+1:0] ref_sum
`endif
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d, widx;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d, e_q, e_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             xfer_in, xfer_out, close;
`ifdef OP4_PACK_REFSUM_EN
  logic [WIDTH+1:0] ref_sum_q, ref_sum_d;
`endif
  always_comb begin
    in_ready = (state_q == FILL) | out_ready;
    xfer_out = (state_q == FULL) & out_ready;
    xfer_in  = in_valid & in_ready;
    // a word accepted while FULL is always the first word of the next group
    widx     = (state_q == FULL) ? 2'd0 : idx_q;
    close    = (widx == 2'd3) | in_last;
    state_d  = xfer_in ? (close ? FULL : FILL) : (xfer_out ? FILL : state_q);
    idx_d    = xfer_in ? (close ? 2'd0 : widx + 2'd1) : (xfer_out ? 2'd0 : idx_q);
    cnt_d    = (xfer_in && close) ? {1'b0, widx} + 3'd1 : cnt_q;
    a_d      = (xfer_in && widx == 2'd0) ? in_data : a_q;
    b_d      = !xfer_in ? b_q : (widx == 2'd1) ? in_data : (widx == 2'd0) ? '0 : b_q;
    d_d      = !xfer_in ? d_q : (widx == 2'd2) ? in_data : (widx == 2'd0) ? '0 : d_q;
    e_d      = !xfer_in ? e_q : (widx == 2'd3) ? in_data : (widx == 2'd0) ? '0 : e_q;
`ifdef OP4_PACK_REFSUM_EN
    ref_sum_d = !xfer_in ? ref_sum_q :
                (widx == 2'd0) ? {2'b00, in_data} : ref_sum_q + {2'b00, in_data};
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= 2'd0;
      cnt_q   <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
`ifdef OP4_PACK_REFSUM_EN
      ref_sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      e_q     <= e_d;
`ifdef OP4_PACK_REFSUM_EN
      ref_sum_q <= ref_sum_d;
`endif
    end
  end
  assign out_valid = (state_q == FULL);
  assign out_count = cnt_q;
  assign a = a_q;
  assign b = b_q;
  assign d = d_q;
  assign e = e_q;
`ifdef OP4_PACK_REFSUM_EN
  assign ref_sum = ref_sum_q;
`endif
endmodule

// File: tb/tb_op4_pack.sv
// tb_op4_pack: directed vector table, reset corner cases and randomized queue-model check for op4_pack.
module tb_op4_pack;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [15:0] a, b, d, e;
  logic [2:0]  out_count;
`ifdef OP4_PACK_REFSUM_EN
  logic [17:0] ref_sum;
`endif
  int n_cmp = 0;
  int n_fail = 0;

  op4_pack #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .a(a), .b(b), .d(d), .e(e), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef OP4_PACK_REFSUM_EN
    , .ref_sum(ref_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        il;
    logic        ordy;
    logic        eir;
    logic        eov;
    logic [15:0] ea, eb, ed, ee;
    logic [2:0]  ec;
  } vec_t;
  vec_t tv[64];
  int   n_tv = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [15:0] id, input logic il, input logic ordy,
                     input logic eir, input logic eov, input logic [15:0] ea, input logic [15:0] eb,
                     input logic [15:0] ed, input logic [15:0] ee, input logic [2:0] ec);
    tv[n_tv] = '{iv, id, il, ordy, eir, eov, ea, eb, ed, ee, ec};
    n_tv++;
  endtask

  task automatic check_out(input string nm, input logic eov, input logic [15:0] ea,
                           input logic [15:0] eb, input logic [15:0] ed, input logic [15:0] ee,
                           input logic [2:0] ec);
    chk({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
    if (eov) begin
      chk({nm, ".a"}, {16'd0, a}, {16'd0, ea});
      chk({nm, ".b"}, {16'd0, b}, {16'd0, eb});
      chk({nm, ".d"}, {16'd0, d}, {16'd0, ed});
      chk({nm, ".e"}, {16'd0, e}, {16'd0, ee});
      chk({nm, ".out_count"}, {29'd0, out_count}, {29'd0, ec});
`ifdef OP4_PACK_REFSUM_EN
      chk({nm, ".ref_sum"}, {14'd0, ref_sum}, 32'(ea) + 32'(eb) + 32'(ed) + 32'(ee));
`endif
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, ".abde"}, {16'd0, a | b | d | e}, 32'd0);
    chk({nm, ".out_count"}, {29'd0, out_count}, 32'd0);
`ifdef OP4_PACK_REFSUM_EN
    chk({nm, ".ref_sum"}, {14'd0, ref_sum}, 32'd0);
`endif
  endtask

  task automatic drive(input logic iv, input logic [15:0] id, input logic il, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    in_last   = il;
    out_ready = ordy;
  endtask

  task automatic step(input string nm, input logic iv, input logic [15:0] id, input logic il,
                      input logic ordy, input logic eov, input logic [15:0] ea, input logic [15:0] eb,
                      input logic [15:0] ed, input logic [15:0] ee, input logic [2:0] ec);
    drive(iv, id, il, ordy);
    @(posedge clk);
    #1;
    check_out(nm, eov, ea, eb, ed, ee, ec);
  endtask

  initial begin
    logic        m_full;
    logic        m_ir;
    logic [15:0] part[$];
    logic [15:0] m_s[4];
    int          m_cnt;
    // reference vectors from the operation rules
    add(1, 16'h0001, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 16'h0002, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 16'h0003, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 16'h0004, 0, 1, 1, 1, 16'h1, 16'h2, 16'h3, 16'h4, 4);
    add(1, 16'hFFFF, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(1, 16'hFFFF, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 16'hFFFF, 0, 0, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4);
    for (int i = 0; i < 5; i++) add(1, 16'hDEAD, 1, 0, 0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4);
    add(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 16'h1234, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 16'h00FF, 1, 1, 1, 1, 16'h1234, 16'h00FF, 0, 0, 2);
    add(1, 16'h0055, 1, 1, 1, 1, 16'h0055, 0, 0, 0, 1);
    add(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      if (k % 4 == 0) add(1, 16'(k), 0, 1, 1, 1, 16'(k - 3), 16'(k - 2), 16'(k - 1), 16'(k), 4);
      else add(1, 16'(k), 0, 1, 1, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_init");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < n_tv; i++) begin
      drive(tv[i].iv, tv[i].id, tv[i].il, tv[i].ordy);
      #1;
      chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].eir});
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), tv[i].eov, tv[i].ea, tv[i].eb, tv[i].ed, tv[i].ee, tv[i].ec);
    end

    // reset mid-group discards the partial words
    step("mid0", 1, 16'hAAAA, 0, 1, 0, 0, 0, 0, 0, 0);
    step("mid1", 1, 16'hBBBB, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    step("clean0", 1, 16'h0010, 0, 1, 0, 0, 0, 0, 0, 0);
    step("clean1", 1, 16'h0011, 0, 1, 0, 0, 0, 0, 0, 0);
    step("clean2", 1, 16'h0012, 0, 1, 0, 0, 0, 0, 0, 0);
    step("clean3", 1, 16'h0013, 0, 0, 1, 16'h10, 16'h11, 16'h12, 16'h13, 4);
    // reset while FULL drops the held group
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("rst_full");
    @(negedge clk);
    rst = 1'b0;
    step("single", 1, 16'h0777, 1, 0, 1, 16'h0777, 0, 0, 0, 1);

    // randomized traffic against a queue-based group model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_full = 1'b0;
    part.delete();
    for (int k = 0; k < 4; k++) m_s[k] = '0;
    m_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0);
      #1;
      m_ir = m_full ? out_ready : 1'b1;
      chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, m_ir});
      if (m_full && out_ready) m_full = 1'b0;
      if (in_valid && m_ir) begin
        part.push_back(in_data);
        if (part.size() == 4 || in_last) begin
          for (int k = 0; k < 4; k++) m_s[k] = (k < part.size()) ? part[k] : 16'h0;
          m_cnt = part.size();
          m_full = 1'b1;
          part.delete();
        end
      end
      @(posedge clk);
      #1;
      check_out("rnd", m_full, m_s[0], m_s[1], m_s[2], m_s[3], 3'(m_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
